// File: rtl/life_seq_ctrl_if.sv
// rtl/life_seq_ctrl_if.sv - button/value inputs and draw handshake bundle for life_seq_ctrl
// GEN_LIMIT_EN adds gen_limit and limit_hit.
interface life_seq_ctrl_if #(
  parameter int NUM_FIELDS = 2,
  parameter int FIELD_W    = 8,
  parameter int GEN_W      = 16
);
  localparam int IDX_W = ($clog2(NUM_FIELDS) < 1) ? 1 : $clog2(NUM_FIELDS);

  logic                          set;
  logic                          go;
  logic                          stop;
  logic                          step_mode;
  logic [FIELD_W-1:0]            val_in;
  logic                          draw_done;
  logic [NUM_FIELDS*FIELD_W-1:0] fields;
  logic [NUM_FIELDS-1:0]         ld_field;
  logic [IDX_W-1:0]              field_idx;
  logic                          draw_req;
  logic [GEN_W-1:0]              gen_count;
  logic [2:0]                    current_state;
`ifdef GEN_LIMIT_EN
  logic [GEN_W-1:0]              gen_limit;
  logic                          limit_hit;

  modport master (
    output set, go, stop, step_mode, val_in, draw_done, gen_limit,
    input  fields, ld_field, field_idx, draw_req, gen_count, current_state, limit_hit
  );
  modport slave (
    input  set, go, stop, step_mode, val_in, draw_done, gen_limit,
    output fields, ld_field, field_idx, draw_req, gen_count, current_state, limit_hit
  );
`else
  modport master (
    output set, go, stop, step_mode, val_in, draw_done,
    input  fields, ld_field, field_idx, draw_req, gen_count, current_state
  );
  modport slave (
    input  set, go, stop, step_mode, val_in, draw_done,
    output fields, ld_field, field_idx, draw_req, gen_count, current_state
  );
`endif
endinterface

// File: rtl/life_seq_ctrl.sv
// rtl/life_seq_ctrl.sv - field loader and generation sequencer for the life simulator
// Optional generation limit enabled by GEN_LIMIT_EN.
module life_seq_ctrl #(
  parameter int NUM_FIELDS = 2,
  parameter int FIELD_W    = 8,
  parameter int GEN_W      = 16
) (
  input  logic          clock_i,
  input  logic          reset_i,
  life_seq_ctrl_if.slave bus
);
  localparam int IDX_W = ($clog2(NUM_FIELDS) < 1) ? 1 : $clog2(NUM_FIELDS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_WAIT = 3'd1,
    S_ARMED     = 3'd2,
    S_DRAW      = 3'd3,
    S_GAP       = 3'd4,
    S_PAUSED    = 3'd5
  } state_e;

  state_e                        state_q, state_d;
  logic [NUM_FIELDS*FIELD_W-1:0] fields_q, fields_d;
  logic [NUM_FIELDS-1:0]         ld_field_q, ld_field_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [GEN_W-1:0]              gen_q, gen_d;
  logic                          stop_pend_q, stop_pend_d;
  logic                          limit_hit_q, limit_hit_d;
  logic                          set_q, go_q, stop_q;
  logic                          set_rise, go_rise, stop_rise, limit_reached;
  logic                          capture;
  logic [IDX_W-1:0]              cap_idx;

  assign set_rise  = bus.set  & ~set_q;
  assign go_rise   = bus.go   & ~go_q;
  assign stop_rise = bus.stop & ~stop_q;

`ifdef GEN_LIMIT_EN
  assign limit_reached = (bus.gen_limit != '0) && (gen_q == bus.gen_limit);
`else
  assign limit_reached = 1'b0;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      fields_q    <= '0;
      ld_field_q  <= '0;
      idx_q       <= '0;
      gen_q       <= '0;
      stop_pend_q <= 1'b0;
      limit_hit_q <= 1'b0;
      set_q       <= 1'b0;
      go_q        <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fields_q    <= fields_d;
      ld_field_q  <= ld_field_d;
      idx_q       <= idx_d;
      gen_q       <= gen_d;
      stop_pend_q <= stop_pend_d;
      limit_hit_q <= limit_hit_d;
      set_q       <= bus.set;
      go_q        <= bus.go;
      stop_q      <= bus.stop;
    end
  end

  always_comb begin
    state_d     = state_q;
    fields_d    = fields_q;
    ld_field_d  = '0;
    idx_d       = idx_q;
    gen_d       = gen_q;
    stop_pend_d = stop_pend_q;
    limit_hit_d = limit_hit_q;
    capture     = 1'b0;
    cap_idx     = '0;
    if (go_rise || set_rise) limit_hit_d = 1'b0;
    case (state_q)
      S_IDLE, S_ARMED, S_PAUSED: begin
        if (set_rise) begin
          // Any set edge outside a run (re)starts the load from field 0.
          capture = 1'b1;
          idx_d   = IDX_W'(1);
          gen_d   = '0;
          state_d = S_LOAD_WAIT;
        end else if (go_rise && state_q != S_IDLE && !(state_q == S_PAUSED && stop_rise)) begin
          state_d = S_DRAW;
        end
      end
      S_LOAD_WAIT: begin
        if (set_rise) begin
          capture = 1'b1;
          cap_idx = idx_q;
          if (idx_q == IDX_W'(NUM_FIELDS - 1)) begin
            idx_d   = '0;
            state_d = S_ARMED;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_DRAW: begin
        if (stop_rise) stop_pend_d = 1'b1;
        if (bus.draw_done) begin
          gen_d   = gen_q + GEN_W'(1);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        // The GAP exit either pauses (consuming the pending stop) or re-requests.
        stop_pend_d = 1'b0;
        if (limit_reached) limit_hit_d = 1'b1;
        if (stop_pend_q || stop_rise || bus.step_mode || limit_reached) state_d = S_PAUSED;
        else state_d = S_DRAW;
      end
      default: state_d = S_IDLE;
    endcase
    if (capture) begin
      fields_d[cap_idx*FIELD_W +: FIELD_W] = bus.val_in;
      ld_field_d[cap_idx]                  = 1'b1;
    end
  end

  always_comb begin
    bus.fields        = fields_q;
    bus.ld_field      = ld_field_q;
    bus.field_idx     = idx_q;
    bus.draw_req      = (state_q == S_DRAW);
    bus.gen_count     = gen_q;
    bus.current_state = state_q;
`ifdef GEN_LIMIT_EN
    bus.limit_hit     = limit_hit_q;
`endif
  end
endmodule

// File: tb/tb_life_seq_ctrl.sv
// tb/tb_life_seq_ctrl.sv - self-checking bench for life_seq_ctrl
module tb_life_seq_ctrl;
  localparam int NF = 2;
  localparam int FW = 8;
  localparam int GW = 16;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_ARMED = 3'd2, ST_DRAW = 3'd3, ST_PAUSED = 3'd5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  life_seq_ctrl_if #(.NUM_FIELDS(NF), .FIELD_W(FW), .GEN_W(GW)) bus ();
  life_seq_ctrl #(.NUM_FIELDS(NF), .FIELD_W(FW), .GEN_W(GW)) dut (
    .clock_i(clock),
    .reset_i(reset),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [FW-1:0] exp_f [NF];
  int exp_gen = 0;
  int req_rises = 0;
  logic req_prev = 1'b0;

  always @(posedge clock) begin
    if (bus.draw_req && !req_prev) req_rises <= req_rises + 1;
    req_prev <= bus.draw_req;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [NF*FW-1:0] packf();
    logic [NF*FW-1:0] v;
    for (int k = 0; k < NF; k++) v[k*FW +: FW] = exp_f[k];
    return v;
  endfunction

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.draw_req) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic load_all();
    for (int k = 0; k < NF; k++) begin
      exp_f[k]   = FW'($urandom);
      bus.val_in = exp_f[k];
      bus.set    = 1'b1;
      cyc(2);
      bus.set = 1'b0;
      cyc(1);
    end
    exp_gen = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    checks++; if (bus.current_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", bus.current_state, ST_IDLE); end
    checks++; if (bus.fields !== '0) begin failures++; $display("FAIL reset_fields got=%0h exp=0", bus.fields); end
    checks++; if (bus.draw_req !== 1'b0 || bus.ld_field !== '0 || bus.field_idx !== '0) begin failures++; $display("FAIL reset_outs req=%0b ld=%0b idx=%0d exp 0", bus.draw_req, bus.ld_field, bus.field_idx); end
    checks++; if (bus.gen_count !== '0) begin failures++; $display("FAIL reset_gen got=%0d exp=0", bus.gen_count); end
    bus.go = 1'b1; bus.stop = 1'b1;
    cyc(2);
    bus.go = 1'b0; bus.stop = 1'b0;
    cyc(1);
    checks++; if (bus.current_state !== ST_IDLE) begin failures++; $display("FAIL idle_ignores_go got=%0d exp=%0d", bus.current_state, ST_IDLE); end
  endtask

  task automatic test_load();
    logic [FW-1:0] vals [NF];
    vals[0] = 8'h12; vals[1] = 8'h34;
    for (int k = 0; k < NF; k++) begin
      exp_f[k]   = vals[k];
      bus.val_in = vals[k];
      bus.set    = 1'b1;
      cyc(1);
      checks++; if (bus.ld_field !== NF'(1 << k)) begin failures++; $display("FAIL load_ld_pulse%0d got=%0b exp=%0b", k, bus.ld_field, NF'(1 << k)); end
      cyc(1);
      checks++; if (bus.ld_field !== '0) begin failures++; $display("FAIL load_ld_single%0d got=%0b exp=0", k, bus.ld_field); end
      bus.val_in = 8'hEE;
      cyc(3);
      bus.set = 1'b0;
      cyc(1);
      checks++; if (bus.field_idx !== 1'((k + 1) % NF)) begin failures++; $display("FAIL load_idx%0d got=%0d exp=%0d", k, bus.field_idx, (k + 1) % NF); end
    end
    checks++; if (bus.fields !== 16'h3412) begin failures++; $display("FAIL load_fields got=%0h exp=3412", bus.fields); end
    checks++; if (bus.current_state !== ST_ARMED) begin failures++; $display("FAIL load_armed got=%0d exp=%0d", bus.current_state, ST_ARMED); end
    exp_gen = 0;
  endtask

  task automatic test_single_step();
    int r0, lat;
    bus.step_mode = 1'b1;
    r0 = req_rises;
    for (int g = 0; g < 3; g++) begin
      bus.go = 1'b1;
      cyc(1);
      bus.go = 1'b0;
      checks++; if (bus.draw_req !== 1'b1) begin failures++; $display("FAIL step_req%0d got=%0b exp=1", g, bus.draw_req); end
      lat = $urandom_range(1, 5);
      cyc(lat);
      bus.draw_done = 1'b1;
      cyc(1);
      bus.draw_done = 1'b0;
      exp_gen++;
      checks++; if (bus.gen_count !== GW'(exp_gen)) begin failures++; $display("FAIL step_gen%0d got=%0d exp=%0d", g, bus.gen_count, exp_gen); end
      cyc(1);
      checks++; if (bus.current_state !== ST_PAUSED || bus.draw_req !== 1'b0) begin failures++; $display("FAIL step_paused%0d state=%0d req=%0b exp state=5 req=0", g, bus.current_state, bus.draw_req); end
      cyc(2);
    end
    checks++; if (req_rises - r0 !== 3) begin failures++; $display("FAIL step_episodes got=%0d exp=3", req_rises - r0); end
  endtask

  task automatic test_continuous();
    bus.step_mode = 1'b0;
    bus.go = 1'b1;
    cyc(1);
    bus.go = 1'b0;
    checks++; if (bus.draw_req !== 1'b1) begin failures++; $display("FAIL cont_go_latency got=%0b exp=1", bus.draw_req); end
    for (int g = 0; g < 3; g++) begin
      cyc(3);
      checks++; if (bus.draw_req !== 1'b1) begin failures++; $display("FAIL cont_req_held%0d got=%0b exp=1", g, bus.draw_req); end
      bus.draw_done = 1'b1;
      cyc(1);
      bus.draw_done = 1'b0;
      exp_gen++;
      checks++; if (bus.draw_req !== 1'b0 || bus.gen_count !== GW'(exp_gen)) begin failures++; $display("FAIL cont_gap%0d req=%0b gen=%0d exp req=0 gen=%0d", g, bus.draw_req, bus.gen_count, exp_gen); end
      cyc(1);
      checks++; if (bus.draw_req !== 1'b1) begin failures++; $display("FAIL cont_rereq%0d got=%0b exp=1", g, bus.draw_req); end
    end
  endtask

  task automatic test_graceful_stop();
    int r0;
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    cyc(4);
    checks++; if (bus.draw_req !== 1'b1) begin failures++; $display("FAIL stop_no_abort got=%0b exp=1", bus.draw_req); end
    bus.draw_done = 1'b1;
    cyc(1);
    bus.draw_done = 1'b0;
    exp_gen++;
    r0 = req_rises;
    checks++; if (bus.gen_count !== GW'(exp_gen)) begin failures++; $display("FAIL stop_gen got=%0d exp=%0d", bus.gen_count, exp_gen); end
    cyc(1);
    checks++; if (bus.current_state !== ST_PAUSED) begin failures++; $display("FAIL stop_paused got=%0d exp=%0d", bus.current_state, ST_PAUSED); end
    cyc(6);
    checks++; if (req_rises !== r0 || bus.draw_req !== 1'b0) begin failures++; $display("FAIL stop_no_more_req rises=%0d exp=%0d", req_rises - r0, 0); end
  endtask

  task automatic test_priority_reload();
    int r0;
    logic [FW-1:0] v;
    checks++; if (bus.gen_count !== 16'd7) begin failures++; $display("FAIL prio_pre_gen got=%0d exp=7", bus.gen_count); end
    r0 = req_rises;
    v = FW'($urandom);
    bus.val_in = v;
    bus.set = 1'b1; bus.go = 1'b1;
    cyc(1);
    bus.set = 1'b0; bus.go = 1'b0;
    exp_f[0] = v; exp_gen = 0;
    checks++; if (bus.current_state !== ST_LOAD || bus.field_idx !== 1'b1) begin failures++; $display("FAIL prio_state state=%0d idx=%0d exp state=1 idx=1", bus.current_state, bus.field_idx); end
    checks++; if (bus.fields[FW-1:0] !== v) begin failures++; $display("FAIL prio_field0 got=%0h exp=%0h", bus.fields[FW-1:0], v); end
    checks++; if (bus.gen_count !== '0) begin failures++; $display("FAIL prio_gen got=%0d exp=0", bus.gen_count); end
    cyc(3);
    checks++; if (req_rises !== r0 || bus.draw_req !== 1'b0) begin failures++; $display("FAIL prio_no_req rises=%0d exp=0", req_rises - r0); end
    v = FW'($urandom);
    bus.val_in = v; bus.set = 1'b1;
    cyc(1);
    bus.set = 1'b0;
    exp_f[1] = v;
    cyc(1);
    checks++; if (bus.fields !== packf() || bus.current_state !== ST_ARMED) begin failures++; $display("FAIL prio_reload fields=%0h state=%0d exp fields=%0h state=2", bus.fields, bus.current_state, packf()); end
  endtask

  task automatic test_random_run();
    int n, lat;
    bit ok;
    for (int rep = 0; rep < 3; rep++) begin
      bus.set = 1'b1; bus.val_in = FW'($urandom);
      exp_f[0] = bus.val_in;
      cyc(1);
      bus.set = 1'b0;
      cyc(1);
      for (int k = 1; k < NF; k++) begin
        exp_f[k] = FW'($urandom);
        bus.val_in = exp_f[k]; bus.set = 1'b1;
        cyc($urandom_range(1, 3));
        bus.set = 1'b0;
        cyc(1);
      end
      exp_gen = 0;
      checks++; if (bus.fields !== packf()) begin failures++; $display("FAIL rand_fields%0d got=%0h exp=%0h", rep, bus.fields, packf()); end
      n = $urandom_range(2, 5);
      bus.step_mode = 1'b0;
      bus.go = 1'b1;
      cyc(1);
      bus.go = 1'b0;
      for (int g = 0; g < n; g++) begin
        wait_req(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rand_req_timeout%0d got=0 exp=1", g); end
        lat = $urandom_range(2, 6);
        if (g == n - 1) begin
          bus.stop = 1'b1;
          cyc(1);
          bus.stop = 1'b0;
          cyc(lat - 1);
        end else begin
          cyc(lat);
        end
        bus.draw_done = 1'b1;
        cyc(1);
        bus.draw_done = 1'b0;
        exp_gen++;
      end
      cyc(1);
      checks++; if (bus.current_state !== ST_PAUSED || bus.gen_count !== GW'(exp_gen)) begin failures++; $display("FAIL rand_run%0d state=%0d gen=%0d exp state=5 gen=%0d", rep, bus.current_state, bus.gen_count, exp_gen); end
      bus.draw_done = 1'b1;
      cyc(2);
      bus.draw_done = 1'b0;
      checks++; if (bus.gen_count !== GW'(exp_gen) || bus.current_state !== ST_PAUSED) begin failures++; $display("FAIL rand_done_ignored%0d gen=%0d exp=%0d", rep, bus.gen_count, exp_gen); end
    end
  endtask

`ifdef GEN_LIMIT_EN
  task automatic test_gen_limit();
    bit ok;
    load_all();
    bus.gen_limit = 16'd2;
    bus.step_mode = 1'b0;
    bus.go = 1'b1;
    cyc(1);
    bus.go = 1'b0;
    for (int g = 0; g < 2; g++) begin
      wait_req(ok);
      checks++; if (!ok) begin failures++; $display("FAIL limit_req_timeout%0d got=0 exp=1", g); end
      cyc(3);
      bus.draw_done = 1'b1;
      cyc(1);
      bus.draw_done = 1'b0;
    end
    cyc(1);
    checks++; if (bus.current_state !== ST_PAUSED || bus.gen_count !== 16'd2 || bus.limit_hit !== 1'b1) begin failures++; $display("FAIL limit_stop state=%0d gen=%0d hit=%0b exp state=5 gen=2 hit=1", bus.current_state, bus.gen_count, bus.limit_hit); end
    bus.go = 1'b1;
    cyc(1);
    bus.go = 1'b0;
    checks++; if (bus.limit_hit !== 1'b0 || bus.draw_req !== 1'b1) begin failures++; $display("FAIL limit_clear hit=%0b req=%0b exp hit=0 req=1", bus.limit_hit, bus.draw_req); end
    bus.gen_limit = '0;
  endtask
`endif

  task automatic test_reset_mid_run();
    load_all();
    bus.go = 1'b1;
    cyc(1);
    bus.go = 1'b0;
    cyc(2);
    checks++; if (bus.draw_req !== 1'b1) begin failures++; $display("FAIL rst_pre_draw got=%0b exp=1", bus.draw_req); end
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    checks++; if (bus.draw_req !== 1'b0 || bus.current_state !== ST_IDLE) begin failures++; $display("FAIL rst_mid state=%0d req=%0b exp state=0 req=0", bus.current_state, bus.draw_req); end
    checks++; if (bus.fields !== '0 || bus.gen_count !== '0 || bus.field_idx !== '0) begin failures++; $display("FAIL rst_mid_regs fields=%0h gen=%0d idx=%0d exp 0", bus.fields, bus.gen_count, bus.field_idx); end
  endtask

  initial begin
    reset = 1'b1;
    bus.set = 1'b0; bus.go = 1'b0; bus.stop = 1'b0; bus.step_mode = 1'b0;
    bus.val_in = '0; bus.draw_done = 1'b0;
`ifdef GEN_LIMIT_EN
    bus.gen_limit = '0;
`endif
    test_reset();
    test_load();
    test_single_step();
    test_continuous();
    test_graceful_stop();
    test_priority_reload();
    test_random_run();
`ifdef GEN_LIMIT_EN
    test_gen_limit();
`endif
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/life_seq_ctrl.md
Name: life_seq_ctrl

Overview:
- Parametrised successor to the coordinate-load/draw controller in the life simulator.
- Loads NUM_FIELDS user values one per `set` press, arms, then runs generations. Each generation is a draw_req/draw_done handshake with the datapath.
- Adds edge-detected buttons, continuous or single-step run mode, graceful stop at a generation boundary, and a generation counter.

Parameters:
- NUM_FIELDS, 2, number of values loaded per configuration (>=2); field 0 = X, field 1 = Y, extras are datapath-defined.
- FIELD_W, 8, width of each loaded value.
- GEN_W, 16, generation counter width.
- IDX_W, $clog2(NUM_FIELDS), field index width (derived localparam, minimum 1).

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state on the clock edge where it is high.
- set  in  1  load button, level; acted on at rising edge only.
- go  in  1  run button, level; rising edge only.
- stop  in  1  stop button, level; rising edge only.
- step_mode  in  1  0 = continuous run, 1 = one generation per go.
- val_in  in  FIELD_W  value captured on a set edge.
- draw_done  in  1  datapath finished the current generation.
- fields  out  NUM_FIELDS*FIELD_W  captured values; field k is at bits [k*FIELD_W +: FIELD_W].
- ld_field  out  NUM_FIELDS  one-hot one-cycle pulse naming the field just captured.
- field_idx  out  IDX_W  next field to be captured.
- draw_req  out  1  generation request, held until draw_done.
- gen_count  out  GEN_W  generations completed since last load.
- current_state  out  3  state encoding (below).

Behaviour:
- Reset values: fields=0, ld_field=0, field_idx=0, draw_req=0, gen_count=0, current_state=IDLE, edge-detect registers=0, stop_pending=0.
- Edge detection: x_rise = x & ~x_q, with x_q registered every cycle. A button held high produces exactly one event.
- State encoding: IDLE=0, LOAD_WAIT=1, ARMED=2, DRAW=3, GAP=4, PAUSED=5. Codes 6 and 7 return to IDLE on the next edge.
- IDLE:
  - set_rise: capture val_in into field 0, field_idx<=1 -> LOAD_WAIT.
  - go and stop are ignored.
- LOAD_WAIT, on set_rise:
  - Capture val_in into fields[field_idx].
  - If field_idx==NUM_FIELDS-1: field_idx<=0 -> ARMED.
  - Else: field_idx++, stay in LOAD_WAIT.
- ld_field: registered. Bit k is high for exactly the one cycle after the capture edge of field k.
- ARMED:
  - set_rise: restart the load (capture field 0, field_idx<=1, gen_count<=0) -> LOAD_WAIT.
  - Else go_rise -> DRAW.
  - set takes priority over go.
- DRAW:
  - draw_req=1 while in this state.
  - draw_done=1: gen_count++ (wraps all-ones -> 0) -> GAP.
  - A stop_rise here or in GAP sets stop_pending. The current generation is never aborted.
  - set is ignored.
- GAP: exactly one cycle with draw_req=0, then:
  - PAUSED if stop_pending, stop_rise, or step_mode=1; clear stop_pending on this transition.
  - Otherwise DRAW.
- PAUSED:
  - set_rise: restart load as in ARMED, gen_count<=0.
  - Else go_rise -> DRAW.
  - stop_rise is a no-op.
  - If go_rise and stop_rise coincide, stay PAUSED.
- Latency:
  - go_rise to draw_req high: 1 cycle.
  - draw_done to gen_count update: same edge.
  - Continuous mode re-request: 2 cycles after draw_done.
- draw_done outside DRAW is ignored.
- Reset mid-DRAW: draw_req low from the next cycle; the datapath must tolerate abandonment.

Optional Feature:
- Macro: GEN_LIMIT_EN.
- When defined, adds:
  - input gen_limit [GEN_W-1:0]
  - output limit_hit (1 bit, reset 0)
- In GAP, if the updated gen_count equals gen_limit and gen_limit!=0, go to PAUSED and set limit_hit.
- limit_hit clears on the next go_rise or set_rise.
- gen_limit=0 means no limit.
- When undefined, neither port exists and runs are unbounded.

Test Plan:
- Load:
  - Stimulus: NUM_FIELDS=2; set pulses with val_in=0x12, then 0x34 (set held 5 cycles each).
  - Response: fields=0x3412; ld_field pulses 01 then 10, one cycle each; state ARMED; field_idx=0.
- Continuous run:
  - Stimulus: step_mode=0, go, datapath answering draw_done 3 cycles after each draw_req.
  - Response: draw_req rises 1 cycle after go_rise; after 4 generations gen_count=4; draw_req low exactly 1 cycle per GAP.
- Graceful stop:
  - Stimulus: stop_rise mid-DRAW with draw_done 5 cycles later.
  - Response: draw_req stays high until done; gen_count increments once more; state PAUSED; no further draw_req.
- Single-step:
  - Stimulus: step_mode=1, three go presses.
  - Response: exactly 3 draw_req episodes; gen_count=3; PAUSED after each.
- Priority and reload:
  - Stimulus: in PAUSED with gen_count=7, set_rise and go_rise in the same cycle.
  - Response: LOAD_WAIT; field 0 captured; gen_count=0; no draw_req.
- Reset mid-run:
  - Stimulus: reset high for 1 cycle during DRAW.
  - Response: next cycle draw_req=0, state IDLE, fields=0, gen_count=0. With GEN_LIMIT_EN and gen_limit=2, a continuous run stops with gen_count=2 and limit_hit=1.
